// File: rtl/servo_frame_gen_pkg.sv
// Shared timing defaults and state encoding for the servo pulse-frame generator.
package servo_pkg;

    localparam int unsigned SERVO_CLK_F    = 100;
    localparam int unsigned SERVO_FRAME_US = 20000;
    localparam int unsigned SERVO_MIN_US   = 500;
    localparam int unsigned SERVO_MAX_US   = 2500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } servo_state_t;

endpackage

// File: rtl/servo_frame_gen_if.sv
// Control/status bundle between the servo tester logic and the frame generator.
interface servo_frame_gen_if;

    logic        enable;
    logic [15:0] pulse_len;
    logic        CONTROL_PIN;
    logic        frame_start;
    logic        clamped;

    modport master (
        output enable,
        output pulse_len,
        input  CONTROL_PIN,
        input  frame_start,
        input  clamped
    );

    modport slave (
        input  enable,
        input  pulse_len,
        output CONTROL_PIN,
        output frame_start,
        output clamped
    );

endinterface

// File: rtl/servo_frame_gen_us_tick.sv
// Microsecond prescaler: free-running 0..CLK_F-1 counter with a one-cycle tick on wrap.
module servo_us_tick #(
    parameter int unsigned CLK_F = 100
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_F - 1);

    logic [PW-1:0] cnt;

    // Tick is decoded from the count only so that a clear driven by the tick is loop-free.
    assign tick = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (!RESET_N || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/servo_frame_gen.sv
// Servo frame generator: fixed-period frames with one clamped high pulse sampled per frame.
//   state   | meaning
//   IDLE    | pin low, waiting for enable
//   HIGH    | pulse phase, pin high until the us counter reaches the latched width
//   LOW     | remainder of the frame, pin low until the us counter reaches FRAME_US
module servo_frame_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_F    = SERVO_CLK_F,
    parameter int unsigned FRAME_US = SERVO_FRAME_US,
    parameter int unsigned MIN_US   = SERVO_MIN_US,
    parameter int unsigned MAX_US   = SERVO_MAX_US
) (
    input logic              CLK,
    input logic              RESET_N,
    servo_frame_gen_if.slave bus
);

    localparam int unsigned UW = $clog2(FRAME_US + 1);
    localparam int unsigned CW = (UW > 16) ? UW : 16;
    localparam logic [15:0]   MIN_W   = 16'(MIN_US);
    localparam logic [15:0]   MAX_W   = 16'(MAX_US);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME_US);

    servo_state_t  state;
    servo_state_t  state_nxt;
    logic [UW-1:0] us_cnt;
    logic [CW-1:0] us_inc;
    logic [15:0]   width_q;
    logic [15:0]   width_d;
    logic          under;
    logic          over;
    logic          tick;
    logic          clear;
    logic          start;
    logic          frame_end;
    logic          hit_w;
    logic          pin_q;
    logic          pin_d;
    logic          fs_q;
    logic          fs_d;
    logic          clamped_q;
    logic          clamped_d;

    servo_us_tick #(.CLK_F(CLK_F)) u_us_tick (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clear   (clear),
        .tick    (tick)
    );

    assign under   = (bus.pulse_len < MIN_W);
    assign over    = (bus.pulse_len > MAX_W);
    assign width_d = under ? MIN_W : (over ? MAX_W : bus.pulse_len);

    assign us_inc    = CW'(us_cnt) + CW'(1);
    assign hit_w     = (state == ST_HIGH) && tick && (us_inc == CW'(width_q));
    // MAX_US < FRAME_US, so the frame can only end from LOW.
    assign frame_end = (state == ST_LOW) && tick && (us_inc == FRAME_C);
    assign start     = bus.enable && ((state == ST_IDLE) || frame_end);
    assign clear     = (state == ST_IDLE) || start;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bus.enable) state_nxt = ST_HIGH;
            ST_HIGH: if (hit_w)      state_nxt = ST_LOW;
            ST_LOW:  if (frame_end)  state_nxt = bus.enable ? ST_HIGH : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pin_d     = (state_nxt == ST_HIGH);
        fs_d      = start;
        clamped_d = start ? (under || over) : clamped_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            us_cnt    <= '0;
            width_q   <= MIN_W;
            pin_q     <= 1'b0;
            fs_q      <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            pin_q     <= pin_d;
            fs_q      <= fs_d;
            clamped_q <= clamped_d;
            if (start) begin
                width_q <= width_d;
            end
            if (clear) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_inc[UW-1:0];
            end
        end
    end

    assign bus.CONTROL_PIN = pin_q;
    assign bus.frame_start = fs_q;
    assign bus.clamped     = clamped_q;

endmodule

// File: tb/tb_servo_frame_gen.sv
// Scoreboard bench for servo_frame_gen: stimulus pushes per-frame expectations, a monitor measures frames.
module tb_servo_frame_gen;

    localparam int CLK_F     = 2;
    localparam int FRAME_US  = 100;
    localparam int MIN_US    = 10;
    localparam int MAX_US    = 50;
    localparam int FRAME_CYC = FRAME_US * CLK_F;

    typedef struct {
        int start;
        int high;
        int clamped;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET_N;

    servo_frame_gen_if bus();

    servo_frame_gen #(
        .CLK_F    (CLK_F),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   cyc_g  = 0;
    logic rst_at_edge = 1'b1;

    exp_t sb[$];
    exp_t cur;
    bit   in_frame = 1'b0;
    int   fcyc;
    int   high_cnt;
    int   clamp_bad;
    bit   fell;
    bit   broken;

    always @(posedge CLK) cyc_g <= cyc_g + 1;
    always @(posedge CLK) rst_at_edge = RESET_N;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_g);
        end
    endtask

    // Reference model: width is the request clamped into [MIN_US, MAX_US], in clock cycles.
    function automatic int model_high(input logic [15:0] p);
        int w;
        w = int'(p);
        if (w < MIN_US) w = MIN_US;
        if (w > MAX_US) w = MAX_US;
        return w * CLK_F;
    endfunction

    function automatic int model_clamped(input logic [15:0] p);
        return ((int'(p) < MIN_US) || (int'(p) > MAX_US)) ? 1 : 0;
    endfunction

    // Monitor: samples on the falling edge, measures each frame and scores it against the queue.
    always @(negedge CLK) begin
        if (!rst_at_edge) begin
            chk("reset_pin", int'(bus.CONTROL_PIN), 0);
            chk("reset_frame_start", int'(bus.frame_start), 0);
            chk("reset_clamped", int'(bus.clamped), 0);
            in_frame = 1'b0;
        end else begin
            if (in_frame && fcyc == FRAME_CYC) begin
                chk("high_cycles", high_cnt, cur.high);
                chk("pin_contiguous", int'(broken), 0);
                chk("clamped_hold", clamp_bad, 0);
                in_frame = 1'b0;
            end
            if (bus.frame_start) begin
                if (in_frame) begin
                    chk("strobe_mid_frame_at", fcyc, FRAME_CYC);
                end else if (sb.size() == 0) begin
                    chk("unexpected_frame_start", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("frame_start_cycle", cyc_g, cur.start);
                    chk("pin_at_start", int'(bus.CONTROL_PIN), 1);
                    in_frame  = 1'b1;
                    fcyc      = 0;
                    high_cnt  = 0;
                    clamp_bad = 0;
                    fell      = 1'b0;
                    broken    = 1'b0;
                end
            end else if (!in_frame && bus.CONTROL_PIN) begin
                chk("idle_pin", 1, 0);
            end
            if (in_frame) begin
                if (bus.CONTROL_PIN) begin
                    high_cnt++;
                    if (fell) broken = 1'b1;
                end else begin
                    fell = 1'b1;
                end
                if (int'(bus.clamped) != cur.clamped) clamp_bad++;
                fcyc++;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one frame starting on the next edge; optional mid-frame pulse_len change, disable, reset.
    task automatic issue_frame(input logic [15:0] p, input int chg_at, input logic [15:0] chg_val,
                               input int dis_at, input int rst_at);
        exp_t e;
        bus.pulse_len = p;
        bus.enable    = 1'b1;
        e.start   = cyc_g + 1;
        e.high    = model_high(p);
        e.clamped = model_clamped(p);
        sb.push_back(e);
        step();
        for (int c = 1; c < FRAME_CYC; c++) begin
            step();
            if (c == chg_at) bus.pulse_len = chg_val;
            if (c == dis_at) bus.enable = 1'b0;
            if (c == rst_at) begin
                RESET_N    = 1'b0;
                bus.enable = 1'b0;
                step();
                RESET_N = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [15:0] p;
        int          r;
        int          dis;

        RESET_N       = 1'b0;
        bus.enable    = 1'b0;
        bus.pulse_len = 16'd0;
        repeat (3) step();
        RESET_N = 1'b1;
        repeat (2) step();

        // Nominal width and back-to-back frames
        issue_frame(16'd30, -1, 16'd0, -1, -1);
        issue_frame(16'd30, -1, 16'd0, -1, -1);
        issue_frame(16'd30, -1, 16'd0, -1, -1);

        // Clamp boundaries, including upstream wrap-around
        issue_frame(16'd0,     -1, 16'd0, -1, -1);
        issue_frame(16'd65436, -1, 16'd0, -1, -1);
        issue_frame(16'd10,    -1, 16'd0, -1, -1);
        issue_frame(16'd50,    -1, 16'd0, -1, -1);

        // Mid-frame change is deferred to the next sample
        issue_frame(16'd30, 20, 16'd40, -1, -1);
        issue_frame(16'd40, -1, 16'd0, -1, -1);

        // Disable mid-pulse, idle gap, re-enable
        issue_frame(16'd30, -1, 16'd0, 10, -1);
        repeat (5) step();
        issue_frame(16'd25, -1, 16'd0, -1, -1);

        // Reset during HIGH of a clamped frame, then a fresh frame
        issue_frame(16'd65436, -1, 16'd0, -1, 30);
        issue_frame(16'd30, -1, 16'd0, -1, -1);

        for (int n = 0; n < 16; n++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0:       p = 16'($urandom_range(0, MIN_US - 1));
                1:       p = 16'(MIN_US);
                2:       p = 16'(MAX_US);
                3:       p = 16'($urandom_range(MAX_US + 1, 65535));
                default: p = 16'($urandom_range(MIN_US, MAX_US));
            endcase
            dis = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME_CYC - 1)) : -1;
            issue_frame(p, int'($urandom_range(1, FRAME_CYC - 1)), 16'($urandom), dis, -1);
            if (dis >= 0) begin
                bus.enable = 1'b0;
                repeat (int'($urandom_range(1, 6))) step();
            end
        end

        bus.enable = 1'b0;
        repeat (FRAME_CYC + 10) step();
        chk("scoreboard_drained", sb.size(), 0);
        chk("frame_closed", int'(in_frame), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
